// File: rtl/axi_pkg.sv
// axi_pkg: definitions shared by the AXI-style BRAM responder.
//   RESP_OKAY / RESP_SLVERR : write response encodings driven on bresp
//   rd_state_e              : read channel FSM states
//   wr_state_e              : write channel FSM states
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/bram_sp.sv
// bram_sp: single-port synchronous RAM, DEPTH words of DATA_W bits.
// The read is registered; on a write the output register takes the
// written data, so a port shows its own write (write-first).
//   clk     : clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module bram_sp #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/axi_bram_responder.sv
// axi_bram_responder: AXI-style read/write responder in front of a
// single-port block RAM.
//   clk, rst                  : clock, synchronous active-high reset
//   araddr/arvalid/arready    : read address channel
//   rdata/rvalid/rready       : read data channel
//   awaddr/awvalid/awready    : write address channel
//   wdata/wvalid/wready       : write data channel (full-word writes)
//   bresp/bvalid/bready       : write response channel
//
// Read FSM
//   state  | meaning
//   R_IDLE | accepting a read address; RAM read launched on acceptance
//   R_MEM  | RAM output settling; captured into rdata at the end
//   R_DATA | rvalid held with stable rdata until rready
// Write FSM
//   state  | meaning
//   W_IDLE | accepting aw+w together; RAM written on acceptance
//   W_RESP | bvalid held with stable bresp until bready
module axi_bram_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rd_state_e         r_state_q;
  wr_state_e         w_state_q;
  logic              ar_oor_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  logic [IDX_W-1:0]  ar_idx;
  logic [IDX_W-1:0]  aw_idx;
  logic              ar_in_range;
  logic              w_ok;
  logic              w_fire;
  logic              ar_fire;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_araddr_lsb;

  assign ar_idx            = araddr[ADDR_W-1:2];
  assign aw_idx            = awaddr[ADDR_W-1:2];
  assign unused_araddr_lsb = ^araddr[1:0];
  assign ar_in_range       = ar_idx < IDX_W'(DEPTH);
  assign w_ok              = (aw_idx < IDX_W'(DEPTH)) && (awaddr[1:0] == 2'b00);

  // Address and data must arrive together; a lone aw or w is left waiting.
  assign awready = !rst && (w_state_q == W_IDLE);
  assign wready  = awready;
  assign w_fire  = awready && awvalid && wvalid;

  // One RAM port: a write acceptance steals the port, so the read waits.
  assign arready = !rst && (r_state_q == R_IDLE) && !w_fire;
  assign ar_fire = arvalid && arready;

  assign mem_we   = w_fire && w_ok;
  assign mem_addr = w_fire ? aw_idx[MEM_AW-1:0] : ar_idx[MEM_AW-1:0];

  bram_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_bram (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata),
    .rdata_o (mem_rdata)
  );

  // Read channel. The RAM samples the address on the acceptance edge, so
  // its output is valid during R_MEM and is frozen into rdata_q; later
  // writes through the shared port cannot disturb the held response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      ar_oor_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            ar_oor_q  <= !ar_in_range;
            r_state_q <= R_MEM;
          end
        end
        R_MEM: begin
          rdata_q   <= ar_oor_q ? '0 : mem_rdata;
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (w_fire) begin
            bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;

endmodule

// File: doc/axi_bram_responder.md
AXI_BRAM_RESPONDER -- requirements
Module: axi_bram_responder

Interface
REQ-001 Parameter ADDR_W, default 20, byte-address width of araddr/awaddr.
REQ-002 Parameter DATA_W, default 32, data width of rdata/wdata.
REQ-003 Parameter DEPTH, default 1024, number of DATA_W-bit words stored.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 araddr  input  ADDR_W  read byte address.
REQ-007 arvalid  input  1  read address valid from initiator.
REQ-008 arready  output  1  read address accepted.
REQ-009 rdata  output  DATA_W  read data word.
REQ-010 rvalid  output  1  read data valid.
REQ-011 rready  input  1  initiator accepts read data.
REQ-012 awaddr  input  ADDR_W  write byte address.
REQ-013 awvalid  input  1  write address valid.
REQ-014 awready  output  1  write address accepted.
REQ-015 wdata  input  DATA_W  write data word; full-word write, no strobes.
REQ-016 wvalid  input  1  write data valid.
REQ-017 wready  output  1  write data accepted.
REQ-018 bvalid  output  1  write response valid.
REQ-019 bready  input  1  initiator accepts write response.
REQ-020 bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.

Function
REQ-021 Word index = addr[ADDR_W-1:2]; addr[1:0] ignored on reads.
REQ-022 Read FSM states: R_IDLE, R_MEM, R_DATA.
REQ-023 R_IDLE: arready=1 combinationally unless a write handshake fires the same cycle; arvalid&&arready -> latch address, go R_MEM.
REQ-024 R_MEM: one-cycle synchronous memory read; arready=0; go R_DATA.
REQ-025 R_DATA: rvalid=1, rdata stable until rvalid&&rready; then R_IDLE. Latency arvalid-handshake to rvalid = 2 cycles.
REQ-026 Read with word index >= DEPTH returns rdata=0; the handshake completes normally.
REQ-027 Write FSM states: W_IDLE, W_RESP.
REQ-028 W_IDLE: awready=wready=1; both handshakes complete only in the same cycle, when awvalid&&wvalid; a lone awvalid or lone wvalid is not accepted.
REQ-029 On acceptance: if index < DEPTH and awaddr[1:0]==0, write wdata and set bresp=OKAY; otherwise no write and bresp=SLVERR; go W_RESP.
REQ-030 W_RESP: awready=wready=0, bvalid=1, bresp stable until bvalid&&bready; then W_IDLE.
REQ-031 Single memory port; simultaneous read and write acceptance is not permitted; write has priority and arready is 0 in that cycle.
REQ-032 A read issued the cycle after a write to the same word returns the new data.
REQ-033 Read and write FSMs are otherwise independent; an outstanding bvalid does not block reads.

Reset
REQ-034 While rst=1: both FSMs return to IDLE; rvalid=0, bvalid=0, bresp=0, rdata=0; arready, awready, wready follow the IDLE values once rst=0.
REQ-035 Reset mid-transaction abandons it; a write not yet accepted is not performed; memory contents are not cleared.

Structure
REQ-036 Shared package axi_pkg holds the bresp constants RESP_OKAY and RESP_SLVERR, and the read/write FSM state enums.
REQ-037 Storage is in one sub-module, bram_sp: single-port synchronous RAM with DEPTH x DATA_W, registered read and write-first behaviour.

Verification
REQ-038 Write 0xDEADBEEF to 0x00010 (aw and w valid together) -> awready/wready handshake in 1 cycle; bvalid with bresp=00; next read of 0x00010 -> rvalid 2 cycles after handshake, rdata=0xDEADBEEF.
REQ-039 awvalid=1 with wvalid=0 for 5 cycles, then wvalid=1 -> no acceptance until the cycle wvalid rises; exactly one write is performed.
REQ-040 Write to 0x00012 (misaligned) or 0x01000 (index 1024) -> bresp=10; the memory word is unchanged on readback.
REQ-041 Read with rready held low for 4 cycles -> rvalid and rdata held stable; no second arready until rready=1.
REQ-042 arvalid and awvalid/wvalid in the same cycle -> write accepted and arready=0; read accepted next cycle and returns the written data.
REQ-043 Assert rst during R_DATA and during W_RESP -> rvalid=0 and bvalid=0 the following cycle; previously written data is still readable after reset.
